prior_event_fifo: RTL

- Downstream consumer of the 4x2 priority encoder (encoder_x4), taking its 2-bit code z and active-high control/valid y.
- Detects new encoder events: valid rising, or code changing while valid.
- Buffers each event in a small show-ahead FIFO and hands it to a slower consumer over a valid/ready handshake.
- Reports full, empty, fill level and a sticky overflow flag.

---
 rtl/prior_event_fifo.sv | 103 ++++++++++
 1 files changed

// File: rtl/prior_event_fifo.sv
// Event-detecting show-ahead FIFO behind the 4x2 priority encoder: new encoder
// events are queued and handed to a slower consumer. Optional stamps: TIMESTAMP_EN.
module prior_event_fifo #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 2,
  parameter int CNT_W  = 4
`ifdef TIMESTAMP_EN
  ,
  parameter int TS_W   = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              valid_in,
  input  logic              clr_ovf,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow
`ifdef TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   out_ts
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              prev_valid;
  logic [CODE_W-1:0] prev_code;
  logic [CODE_W-1:0] mem [DEPTH];

  logic evt;
  logic push;
  logic pop;
  logic drop;

  // Handshake: out_valid/out_code describe the head entry; the head is consumed
  // on any rising edge where out_valid & out_ready, and out_valid never depends
  // on out_ready.
  always_comb begin
    evt  = valid_in & (~prev_valid | (code_in != prev_code));
    pop  = out_valid & out_ready;
    push = evt & (~full | pop);
    drop = evt & full & ~pop;
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign out_valid = ~empty;
  // Gate the head so stale memory never leaks out after reset.
  assign out_code  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      prev_valid <= 1'b0;
      prev_code  <= '0;
    end else begin
      prev_valid <= valid_in;
      prev_code  <= code_in;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A fresh drop outranks a simultaneous clear.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code_in;
  end

`ifdef TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) ts_mem[wr_ptr] <= ts_cnt;
  end

  assign out_ts = empty ? '0 : ts_mem[rd_ptr];
`endif

endmodule
